// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 decryptor: one round per clock. The round-10 key is derived by forward
// expansion and cached, so repeated blocks under the same key skip the expansion.
//   state  | meaning
//   IDLE   | waiting for a block, in_ready=1
//   EXPAND | forward key schedule rk0 -> rk10, 10 cycles
//   ARK    | initial AddRoundKey with rk10
//   ROUND  | inverse rounds r=9..0
//   DONE   | plaintext held on out_data until out_ready
module aes128_dec_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         key_hit
);

    typedef enum logic [2:0] {S_IDLE, S_EXPAND, S_ARK, S_ROUND, S_DONE} state_t;

    state_t       r_fsm, w_fsm_next;
    logic [127:0] r_blk, r_key, r_cache_key0, r_cache_rk10, r_out_data;
    logic [3:0]   r_cnt;
    logic         r_cache_vld, r_key_hit;
    logic         w_hit;
    logic [127:0] w_sub_shift, w_key_fwd, w_key_inv;
    logic [7:0]   w_inv_rcon;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq, r;
        sq = x;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return o;
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0] ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ sub_rot_word(n3) ^ {rc, 24'h0};
        return {n0, n1, n2, n3};
    endfunction

    // Stepping rk_i back to rk_(i-1) uses Rcon(i); ARK holds rk10 with no round index yet.
    assign w_inv_rcon  = rcon((r_fsm == S_ARK) ? 4'd10 : r_cnt);
    assign w_hit       = r_cache_vld && (in_key == r_cache_key0);
    assign w_sub_shift = inv_sub_shift(r_blk);
    assign w_key_fwd   = key_fwd(r_key, rcon(r_cnt));
    assign w_key_inv   = key_inv(r_key, w_inv_rcon);
    assign out_data    = r_out_data;
    assign key_hit     = r_key_hit;

    always_ff @(posedge clk) begin
        if (rst) r_fsm <= S_IDLE;
        else     r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_fsm_next = w_hit ? S_ARK : S_EXPAND;
            end
            S_EXPAND: if (r_cnt == 4'd10) w_fsm_next = S_ARK;
            S_ARK:    w_fsm_next = S_ROUND;
            S_ROUND:  if (r_cnt == 4'd0) w_fsm_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_next = S_IDLE;
            end
            default:  w_fsm_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk        <= '0;
            r_key        <= '0;
            r_cnt        <= '0;
            r_cache_key0 <= '0;
            r_cache_rk10 <= '0;
            r_cache_vld  <= 1'b0;
            r_out_data   <= '0;
            r_key_hit    <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_blk        <= in_data;
                        r_cache_key0 <= in_key;
                        r_key_hit    <= w_hit;
                        if (w_hit) begin
                            r_key <= r_cache_rk10;
                        end else begin
                            r_key       <= in_key;
                            r_cnt       <= 4'd1;
                            r_cache_vld <= 1'b0;
                        end
                    end
                end
                S_EXPAND: begin
                    r_key <= w_key_fwd;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd10) begin
                        r_cache_rk10 <= w_key_fwd;
                        r_cache_vld  <= 1'b1;
                    end
                end
                S_ARK: begin
                    r_blk <= r_blk ^ r_key;
                    r_key <= w_key_inv;
                    r_cnt <= 4'd9;
                end
                S_ROUND: begin
                    if (r_cnt != 4'd0) begin
                        r_blk <= inv_mix_cols(w_sub_shift ^ r_key);
                        r_key <= w_key_inv;
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_out_data <= w_sub_shift ^ r_key;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_dec_iter.sv
// Self-checking bench for aes128_dec_iter: FIPS-197 vectors, key cache hit/miss latency,
// backpressure, mid-block reset and a continuous-offer stream, scored through a queue.
module tb_aes128_dec_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         key_hit;

    aes128_dec_iter dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .key_hit(key_hit)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] pt;
        logic         hit;
        int           lat;
        int           acc;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad = 0;
    logic         m_vld = 1'b0;
    logic [127:0] m_key = '0;

    // Cache model: one entry, filled by every miss, emptied by reset.
    task automatic push_exp(input logic [127:0] key, input logic [127:0] pt, input int acc,
                            output exp_t e);
        e.pt  = pt;
        e.hit = m_vld && (key == m_key);
        e.lat = e.hit ? 12 : 22;
        e.acc = acc;
        if (!e.hit) begin
            m_key = key;
            m_vld = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        m_vld = 1'b0;
        exp_q.delete();
    endtask

    task automatic accept_block(input logic [127:0] key, input logic [127:0] ct,
                                input logic [127:0] pt, output bit to);
        int   n;
        exp_t e;
        n        = 0;
        to       = 1'b0;
        in_valid = 1'b1;
        in_data  = ct;
        in_key   = key;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            to       = 1'b1;
            in_valid = 1'b0;
            return;
        end
        push_exp(key, pt, 0, e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~ct;
        in_key   = ~key;
    endtask

    task automatic wait_output(output int lat, output bit to);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        to = !out_valid;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 128'h0) begin bad++; $display("FAIL rst_out_data got=%h want=0", out_data); end
        total++; if (key_hit !== 1'b0) begin bad++; $display("FAIL rst_key_hit got=%b want=0", key_hit); end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_vectors();
        logic [127:0] tk[4];
        logic [127:0] tc[4];
        logic [127:0] tp[4];
        bit           to;
        int           lat;
        exp_t         e;
        tk = '{K1, K1, K2, K1};
        tc = '{C1, C1, C2, C1};
        tp = '{P1, P1, P2, P1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            accept_block(tk[i], tc[i], tp[i], to);
            total++;
            if (to) begin bad++; $display("FAIL vec%0d_accept timeout got=no_accept want=accept", i); return; end
            wait_output(lat, to);
            e = exp_q.pop_front();
            total++;
            if (to) begin bad++; $display("FAIL vec%0d_out timeout got=no_valid want=valid", i); return; end
            total++; if (out_data !== e.pt) begin bad++; $display("FAIL vec%0d_data got=%h want=%h", i, out_data, e.pt); end
            total++; if (key_hit !== e.hit) begin bad++; $display("FAIL vec%0d_hit got=%b want=%b", i, key_hit, e.hit); end
            total++; if (lat != e.lat) begin bad++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, e.lat); end
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0 || out_data !== e.pt) begin
                bad++;
                $display("FAIL vec%0d_hold got=%b/%h want=0/%h", i, out_valid, out_data, e.pt);
            end
        end
    endtask

    task automatic test_backpressure();
        bit   to;
        int   lat;
        exp_t e;
        out_ready = 1'b0;
        accept_block(K1, C1, P1, to);
        total++;
        if (to) begin bad++; $display("FAIL bp_accept timeout got=no_accept want=accept"); return; end
        wait_output(lat, to);
        e = exp_q.pop_front();
        total++;
        if (to) begin bad++; $display("FAIL bp_out timeout got=no_valid want=valid"); out_ready = 1'b1; return; end
        total++; if (out_data !== e.pt) begin bad++; $display("FAIL bp_data got=%h want=%h", out_data, e.pt); end
        total++; if (key_hit !== e.hit) begin bad++; $display("FAIL bp_hit got=%b want=%b", key_hit, e.hit); end
        total++; if (lat != e.lat) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, e.lat); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e.pt) begin
                bad++;
                $display("FAIL bp_stall%0d got=v%b r%b %h want=v1 r0 %h", i, out_valid, in_ready, out_data, e.pt);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== e.pt) begin
            bad++;
            $display("FAIL bp_release got=r%b v%b %h want=r1 v0 %h", in_ready, out_valid, out_data, e.pt);
        end
    endtask

    task automatic test_reset_mid_round();
        bit   to;
        int   lat;
        exp_t e;
        out_ready = 1'b1;
        accept_block(K2, C2, P2, to);
        total++;
        if (to) begin bad++; $display("FAIL rmr_accept timeout got=no_accept want=accept"); return; end
        repeat (14) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmr_pre got=%b want=0", out_valid); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_front());
        m_vld = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmr_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 128'h0) begin bad++; $display("FAIL rmr_out_data got=%h want=0", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmr_in_ready got=%b want=1", in_ready); end
        accept_block(K2, C2, P2, to);
        total++;
        if (to) begin bad++; $display("FAIL rmr2_accept timeout got=no_accept want=accept"); return; end
        wait_output(lat, to);
        e = exp_q.pop_front();
        total++;
        if (to) begin bad++; $display("FAIL rmr2_out timeout got=no_valid want=valid"); return; end
        total++; if (out_data !== e.pt) begin bad++; $display("FAIL rmr2_data got=%h want=%h", out_data, e.pt); end
        total++; if (key_hit !== e.hit) begin bad++; $display("FAIL rmr2_hit got=%b want=%b", key_hit, e.hit); end
        total++; if (lat != e.lat) begin bad++; $display("FAIL rmr2_latency got=%0d want=%0d", lat, e.lat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        int   n_acc, n_out, last_acc, last_lat, exp_n, t;
        exp_t e;
        localparam int W = 150;
        do_reset();
        n_acc    = 0;
        n_out    = 0;
        last_acc = 0;
        last_lat = 0;
        exp_n    = 1;
        t        = 23;
        while (t < W) begin
            exp_n++;
            t += 13;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = C1;
        in_key    = K1;
        for (int c = 0; c < W + 40; c++) begin
            if (c == W) in_valid = 1'b0;
            if (c >= W && exp_q.size() == 0) break;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_extra_output cycle=%0d got=%h want=none", c, out_data);
                end else begin
                    e = exp_q.pop_front();
                    n_out++;
                    if (out_data !== e.pt) begin bad++; $display("FAIL stream_data%0d got=%h want=%h", n_out, out_data, e.pt); end
                    total++; if (key_hit !== e.hit) begin bad++; $display("FAIL stream_hit%0d got=%b want=%b", n_out, key_hit, e.hit); end
                    total++; if (c - e.acc != e.lat) begin bad++; $display("FAIL stream_lat%0d got=%0d want=%0d", n_out, c - e.acc, e.lat); end
                end
            end
            if (in_valid && in_ready) begin
                if (n_acc > 0) begin
                    total++;
                    if (c - last_acc != last_lat + 1) begin
                        bad++;
                        $display("FAIL stream_interval%0d got=%0d want=%0d", n_acc, c - last_acc, last_lat + 1);
                    end
                end
                push_exp(K1, P1, c, e);
                last_acc = c;
                last_lat = e.lat;
                n_acc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        total++; if (n_acc != exp_n) begin bad++; $display("FAIL stream_accepts got=%0d want=%0d", n_acc, exp_n); end
        total++; if (n_out != n_acc) begin bad++; $display("FAIL stream_outputs got=%0d want=%0d", n_out, n_acc); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stream_pending got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_round();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
